multiplier_iterbaughwooleyctrl: RTL

- Iterative signed (two's-complement) multiplier controller.
- Sequences one row of Baugh-Wooley array cells per cycle over a shift/accumulate datapath: one partial-product row per cycle, WIDTH cycles per product.
- Val/rdy request/response interfaces; used by the LK gradient-product stage wherever a full combinational array is too large.

---
 rtl/multiplier_iterbaughwooleyctrl_pkg.sv | 21 ++
 rtl/multiplier_iterbaughwooleyctrl_if.sv | 23 ++
 rtl/multiplier_iterbaughwooleyctrl_row.sv | 50 +++++
 rtl/multiplier_iterbaughwooleyctrl.sv | 101 ++++++++++
 4 files changed

// File: rtl/multiplier_iterbaughwooleyctrl_pkg.sv
// Shared definitions for the iterative Baugh-Wooley multiplier: FSM encoding,
// counter sizing and the constant that completes the Baugh-Wooley sum.
package multiplier_iterbaughwooleyctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Row counter must index rows 0..w-1.
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  // Baugh-Wooley correction: +2^w and +2^(2w-1), taken mod 2^(2w) by the caller.
  function automatic logic [63:0] bw_corr(input int w);
    return (64'd1 << w) | (64'd1 << (2 * w - 1));
  endfunction

endpackage

// File: rtl/multiplier_iterbaughwooleyctrl_if.sv
// Request/response handshake bundle for the iterative multiplier.
interface multiplier_iterbaughwooleyctrl_if #(
  parameter int WIDTH = 16
);
  logic                      req_val;
  logic                      req_rdy;
  logic signed [WIDTH-1:0]   req_a;
  logic signed [WIDTH-1:0]   req_b;
  logic                      resp_val;
  logic                      resp_rdy;
  logic signed [2*WIDTH-1:0] resp_prod;
  logic                      busy;

  modport master (
    output req_val, req_a, req_b, resp_rdy,
    input  req_rdy, resp_val, resp_prod, busy
  );

  modport slave (
    input  req_val, req_a, req_b, resp_rdy,
    output req_rdy, resp_val, resp_prod, busy
  );
endinterface

// File: rtl/multiplier_iterbaughwooleyctrl_row.sv
// One Baugh-Wooley partial-product row added into the upper accumulator slice
// through a ripple chain of array cells.
module multiplier_iterbaughwooleyctrl_cell (
  input  logic a,
  input  logic b,
  input  logic inv,
  input  logic s_in,
  input  logic c_in,
  output logic s_out,
  output logic c_out
);
  logic pp;

  assign pp    = (a & b) ^ inv;
  assign s_out = pp ^ s_in ^ c_in;
  assign c_out = (pp & s_in) | (pp & c_in) | (s_in & c_in);
endmodule

module multiplier_iterbaughwooleyctrl_row #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic             b_bit,
  input  logic             last,
  input  logic [WIDTH-1:0] acc_slice,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  logic [WIDTH:0] c;

  assign c[0] = 1'b0;

  // Ordinary rows complement only the sign column; the last row complements
  // every column except the sign column.
  for (genvar j = 0; j < WIDTH; j++) begin : g_cell
    localparam logic IS_MSB = (j == WIDTH - 1);

    multiplier_iterbaughwooleyctrl_cell u_cell (
      .a     (a[j]),
      .b     (b_bit),
      .inv   (last ^ IS_MSB),
      .s_in  (acc_slice[j]),
      .c_in  (c[j]),
      .s_out (sum[j]),
      .c_out (c[j+1])
    );
  end

  assign carry = c[WIDTH];
endmodule

// File: rtl/multiplier_iterbaughwooleyctrl.sv
// Iterative signed multiplier: one Baugh-Wooley row per cycle over a
// right-shifting 2*WIDTH accumulator, val/rdy on both sides.
module multiplier_iterbaughwooleyctrl
  import multiplier_iterbaughwooleyctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                          clk,
  input logic                          reset,
  multiplier_iterbaughwooleyctrl_if.slave bus
);
  localparam int                  CW        = cnt_w(WIDTH);
  localparam logic [CW-1:0]       LAST_ROW  = CW'(WIDTH - 1);
  localparam logic [63:0]         CORR_FULL = bw_corr(WIDTH);
  localparam logic [2*WIDTH-1:0]  CORR      = CORR_FULL[2*WIDTH-1:0];

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;

  logic                 last_row;
  logic [WIDTH-1:0]     row_sum;
  logic                 row_carry;
  logic [2*WIDTH-1:0]   acc_shift;

  assign last_row = (cnt_q == LAST_ROW);

  multiplier_iterbaughwooleyctrl_row #(
    .WIDTH (WIDTH)
  ) u_row (
    .a         (a_q),
    .b_bit     (b_q[0]),
    .last      (last_row),
    .acc_slice (acc_q[2*WIDTH-1:WIDTH]),
    .sum       (row_sum),
    .carry     (row_carry)
  );

  // Row i lands on the upper half, then everything moves down one place, so
  // after WIDTH rows each row sits at weight 2^i with no bits lost.
  assign acc_shift = {row_carry, row_sum, acc_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_val) begin
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        b_d = b_q >> 1;
        if (last_row) begin
          acc_d   = acc_shift + CORR;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          acc_d = acc_shift;
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.resp_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.req_rdy   = (state_q == ST_IDLE);
  assign bus.resp_val  = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.resp_prod = acc_q;
endmodule
